// File: rtl/mc_pkg.sv
// mc_pkg -- shared types and constants for the multi-cycle MIPS control unit.
//   state_e      : controller FSM states
//   OP_*         : IR[31:26] opcodes of the supported ISA subset
//   alu_op_e / alu_src_b_e / pc_src_e : datapath mux and ALU encodings
//   ctrl_t       : bundle of every datapath strobe driven by the controller
//   G_* / seg_word : 7-segment glyphs (active-high a..g in [6:0]) and packer
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_FAULT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_AND = 2'b11} alu_op_e;
  typedef enum logic [1:0] {SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} alu_src_b_e;
  typedef enum logic [1:0] {PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RSVD = 2'b11} pc_src_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_src_e    pc_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Glyphs, active-high, bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] G_BLANK = 7'h00;
  localparam logic [6:0] G_A = 7'h77, G_R = 7'h05, G_I = 7'h30, G_T = 7'h0F;
  localparam logic [6:0] G_D = 7'h3D, G_SI = 7'h10, G_N = 7'h15, G_L = 7'h0E;
  localparam logic [6:0] G_U = 7'h1C, G_S = 7'h5B, G_B = 7'h1F, G_E = 7'h4F;
  localparam logic [6:0] G_Q = 7'h73, G_J = 7'h38;

  localparam logic [34:0] SEG_BLANK = '1;

  // Packs five glyphs (d4 leftmost) into the active-low display word.
  function automatic logic [34:0] seg_word(input logic [6:0] d4, input logic [6:0] d3,
                                           input logic [6:0] d2, input logic [6:0] d1,
                                           input logic [6:0] d0);
    return ~{d4, d3, d2, d1, d0};
  endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if -- controller <-> datapath bundle.
//   opcode, mem_ready           : datapath -> controller
//   ctrl, fault, instr_count, seg : controller -> datapath / front panel
// Modports: master = controller side, slave = datapath side.
interface mc_if
  import mc_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  ctrl_t            ctrl;
  logic             fault;
  logic [CNT_W-1:0] instr_count;
  logic [34:0]      seg;

  modport master (input opcode, mem_ready, output ctrl, fault, instr_count, seg);
  modport slave  (output opcode, mem_ready, input ctrl, fault, instr_count, seg);
endinterface

// File: rtl/mc_core.sv
// mc_core -- multi-cycle control FSM, memory wait/timeout counter, retire counter.
//   clk, rst_n : clock, async active-low reset
//   bus        : mc_if.master (opcode/mem_ready in; strobes, fault, count, seg out)
// Strobes are registered from the next state so they line up with the state
// register; only the FETCH IRWrite/PCWrite pair is gated by the live mem_ready.
// Optional front-panel mnemonic display under `define MC_SEG_DISPLAY_EN.
module mc_core
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst_n,
  mc_if.master bus
);
  // Last wait cycle: no ready here means the access has timed out.
  localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d, ctrl_o;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fault_q, fault_d;
  logic             retire;

  // State register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the state starts in FETCH but the strobes reset to idle, so the
    // first cycle after reset issues no memory request.
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= CTRL_IDLE;
      wait_q  <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    wait_d  = wait_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_EXEC;
          OP_ADDI, OP_ANDI: state_d = S_IEXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_FAULT;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FAULT;
    endcase

    // Memory wait: ready on the last allowed cycle still wins.
    if (state_q inside {S_FETCH, S_MEMRD, S_MEMWR} && !bus.mem_ready) begin
      wait_d = wait_q + 1'b1;
      if (wait_q == WAIT_LAST) state_d = S_FAULT;
    end
    if (state_d != state_q && state_d inside {S_FETCH, S_MEMRD, S_MEMWR}) wait_d = '0;

    count_d = count_q + CNT_W'(retire);
    fault_d = fault_q | (state_d == S_FAULT);
  end

  // Output logic: strobes for the state being entered.
  always_comb begin
    ctrl_d = CTRL_IDLE;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.ir_write  = 1'b1;  // armed; qualified by mem_ready below
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: ctrl_d.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = (bus.opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
      end
      S_IWB: ctrl_d.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_src        = PC_ALUOUT;
        ctrl_d.bne           = (bus.opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl_d.pc_write = 1'b1;
        ctrl_d.pc_src   = PC_JUMP;
      end
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

  // The fetch pair loads IR and PC only in the cycle memory delivers.
  always_comb begin
    ctrl_o          = ctrl_q;
    ctrl_o.ir_write = ctrl_q.ir_write & bus.mem_ready;
    ctrl_o.pc_write = ctrl_q.pc_write & (~ctrl_q.ir_write | bus.mem_ready);
  end

  assign bus.ctrl        = ctrl_o;
  assign bus.fault       = fault_q;
  assign bus.instr_count = count_q;

`ifdef MC_SEG_DISPLAY_EN
  logic [34:0] seg_q, seg_d, glyph;

  mc_seg_rom u_seg_rom (.opcode(bus.opcode), .seg(glyph));

  always_comb begin
    seg_d = seg_q;
    if (state_d == S_FAULT)       seg_d = seg_word(G_E, G_R, G_R, G_BLANK, G_BLANK);
    else if (state_q == S_DECODE) seg_d = glyph;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= SEG_BLANK;
    else        seg_q <= seg_d;
  end

  assign bus.seg = seg_q;
`else
  assign bus.seg = SEG_BLANK;
`endif

endmodule

// File: rtl/mc_seg_rom.sv
// mc_seg_rom -- opcode to five-digit mnemonic glyph lookup (active-low).
//   opcode : IR[31:26]
//   seg    : 35-bit display word, [34:28] leftmost digit; unknown opcodes show "Err"
module mc_seg_rom
  import mc_pkg::*;
(
  input  logic [5:0]  opcode,
  output logic [34:0] seg
);
  always_comb begin
    case (opcode)
      OP_RTYPE: seg = seg_word(G_A, G_R, G_I, G_T, G_BLANK);
      OP_ADDI:  seg = seg_word(G_A, G_D, G_D, G_SI, G_BLANK);
      OP_ANDI:  seg = seg_word(G_A, G_N, G_D, G_SI, G_BLANK);
      OP_LW:    seg = seg_word(G_L, G_U, G_BLANK, G_BLANK, G_BLANK);
      OP_SW:    seg = seg_word(G_S, G_U, G_BLANK, G_BLANK, G_BLANK);
      OP_BEQ:   seg = seg_word(G_B, G_E, G_Q, G_BLANK, G_BLANK);
      OP_BNE:   seg = seg_word(G_B, G_N, G_E, G_BLANK, G_BLANK);
      OP_J:     seg = seg_word(G_J, G_BLANK, G_BLANK, G_BLANK, G_BLANK);
      default:  seg = seg_word(G_E, G_R, G_R, G_BLANK, G_BLANK);
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control -- multi-cycle MIPS control unit (R-type, addi, andi,
// lw, sw, beq, bne, j) between the IR and a shared-memory datapath.
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_opcode, i_zero       : IR[31:26], ALU zero flag (used by the datapath PC-load gate)
//   i_mem_ready            : memory completes the current access this cycle
//   o_PCWrite .. o_PCSrc   : datapath strobes
//   o_fault, o_instr_count : sticky fault, wrapping retired-instruction count
//   o_seg                  : five active-low 7-seg digits (`define MC_SEG_DISPLAY_EN)
module multicycle_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int TMO_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_PCWrite,
  output logic             o_PCWriteCond,
  output logic             o_Bne,
  output logic             o_IorD,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic             o_IRWrite,
  output logic             o_MemtoReg,
  output logic             o_RegDst,
  output logic             o_RegWrite,
  output logic             o_ALUSrcA,
  output logic [1:0]       o_ALUSrcB,
  output logic [1:0]       o_ALUOp,
  output logic [1:0]       o_PCSrc,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [34:0]      o_seg
);
  mc_if #(.CNT_W(CNT_W)) bus ();

  // The zero flag is combined with o_Bne in the datapath, not here.
  logic unused_zero;
  assign unused_zero = i_zero;

  assign bus.opcode    = i_opcode;
  assign bus.mem_ready = i_mem_ready;

  mc_core #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMO_W      (TMO_W),
    .CNT_W      (CNT_W)
  ) u_core (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .bus  (bus.master)
  );

  assign o_PCWrite     = bus.ctrl.pc_write;
  assign o_PCWriteCond = bus.ctrl.pc_write_cond;
  assign o_Bne         = bus.ctrl.bne;
  assign o_IorD        = bus.ctrl.iord;
  assign o_MemRead     = bus.ctrl.mem_read;
  assign o_MemWrite    = bus.ctrl.mem_write;
  assign o_IRWrite     = bus.ctrl.ir_write;
  assign o_MemtoReg    = bus.ctrl.mem_to_reg;
  assign o_RegDst      = bus.ctrl.reg_dst;
  assign o_RegWrite    = bus.ctrl.reg_write;
  assign o_ALUSrcA     = bus.ctrl.alu_src_a;
  assign o_ALUSrcB     = bus.ctrl.alu_src_b;
  assign o_ALUOp       = bus.ctrl.alu_op;
  assign o_PCSrc       = bus.ctrl.pc_src;
  assign o_fault       = bus.fault;
  assign o_instr_count = bus.instr_count;
  assign o_seg         = bus.seg;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control -- directed bench for multicycle_control
// (TIMEOUT_CYC=4, CNT_W=2). Strobes are compared as one 17-bit vector:
// {PCWrite,PCWriteCond,Bne,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
//  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSrc[1:0]}.
module tb_multicycle_control;

  localparam logic [16:0] V_IDLE    = 17'b0;
  localparam logic [16:0] V_FETCH_W = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] V_FETCH_R = 17'b1_0_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [16:0] V_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] V_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [16:0] V_ANDI    = 17'b0_0_0_0_0_0_0_0_0_0_1_10_11_00;
  localparam logic [16:0] V_MEMRD   = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_MEMWB   = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [16:0] V_MEMWR   = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_EXEC    = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [16:0] V_ALUWB   = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [16:0] V_IWB     = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_00;
  localparam logic [16:0] V_BNE     = 17'b0_1_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] V_BEQ     = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] V_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_J = 6'b000010, OP_BAD = 6'b111111;

  localparam logic [34:0] SEG_OFF = 35'h7_FFFF_FFFF;
  localparam logic [34:0] SEG_ERR = 35'b0110000_1111010_1111010_1111111_1111111;

  logic clk = 1'b0;
  logic rst_n;
  logic zero;
  logic pc_write, pc_write_cond, bne, iord, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [16:0] sv;
  int total = 0;
  int bad = 0;

  mc_if #(.CNT_W(2)) dp ();

  multicycle_control #(.TIMEOUT_CYC(4), .TMO_W(8), .CNT_W(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_opcode     (dp.opcode),
    .i_zero       (zero),
    .i_mem_ready  (dp.mem_ready),
    .o_PCWrite    (pc_write),
    .o_PCWriteCond(pc_write_cond),
    .o_Bne        (bne),
    .o_IorD       (iord),
    .o_MemRead    (mem_read),
    .o_MemWrite   (mem_write),
    .o_IRWrite    (ir_write),
    .o_MemtoReg   (mem_to_reg),
    .o_RegDst     (reg_dst),
    .o_RegWrite   (reg_write),
    .o_ALUSrcA    (alu_src_a),
    .o_ALUSrcB    (alu_src_b),
    .o_ALUOp      (alu_op),
    .o_PCSrc      (pc_src),
    .o_fault      (dp.fault),
    .o_instr_count(dp.instr_count),
    .o_seg        (dp.seg)
  );

  always #5 clk = ~clk;

  assign sv = {pc_write, pc_write_cond, bne, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic rdy, input logic [5:0] op);
    dp.mem_ready = rdy;
    dp.opcode    = op;
    #1;
  endtask

  // Fetch with immediate ready, then leave DECODE; ends sampled in the state after DECODE.
  task automatic fetch_decode(input logic [5:0] op);
    set(1'b1, op);
    tick();
    set(1'b0, op);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    zero  = 1'b0;
    dp.mem_ready = 1'b0;
    dp.opcode    = OP_R;
    #2;
    check("rst_strobes", 35'(sv), 35'(V_IDLE));
    check("rst_fault", 35'(dp.fault), 35'd0);
    check("rst_count", 35'(dp.instr_count), 35'd0);
    check("rst_seg", dp.seg, SEG_OFF);
    #10 rst_n = 1'b1;
    #1 check("post_rst_idle", 35'(sv), 35'(V_IDLE));
    tick();
    check("fetch_wait", 35'(sv), 35'(V_FETCH_W));

    // R-type, ready immediately: FETCH, DECODE, EXEC, ALUWB.
    set(1'b1, OP_R);
    check("r_fetch_rdy", 35'(sv), 35'(V_FETCH_R));
    tick(); set(1'b0, OP_R);
    check("r_decode", 35'(sv), 35'(V_DECODE));
    tick(); check("r_exec", 35'(sv), 35'(V_EXEC));
    tick(); check("r_aluwb", 35'(sv), 35'(V_ALUWB));
    check("r_cnt_pre", 35'(dp.instr_count), 35'd0);
    tick(); check("r_cnt", 35'(dp.instr_count), 35'd1);
    check("r_back_fetch", 35'(sv), 35'(V_FETCH_W));

    // lw: two wait cycles in FETCH and in MEMRD.
    set(1'b0, OP_LW);
    tick(); tick();
    check("lw_fetch_wait", 35'(sv), 35'(V_FETCH_W));
    set(1'b1, OP_LW);
    check("lw_fetch_rdy", 35'(sv), 35'(V_FETCH_R));
    tick(); set(1'b0, OP_LW);
    check("lw_decode", 35'(sv), 35'(V_DECODE));
    tick(); check("lw_memadr", 35'(sv), 35'(V_MEMADR));
    tick(); check("lw_memrd", 35'(sv), 35'(V_MEMRD));
    tick(); tick();
    set(1'b1, OP_LW);
    check("lw_memrd_rdy", 35'(sv), 35'(V_MEMRD));
    tick(); set(1'b0, OP_LW);
    check("lw_memwb", 35'(sv), 35'(V_MEMWB));
    tick(); check("lw_cnt", 35'(dp.instr_count), 35'd2);

    // bne taken (zero=0) and not taken (zero=1).
    zero = 1'b0;
    fetch_decode(OP_BNE);
    check("bne_z0_vec", 35'(sv), 35'(V_BNE));
    check("bne_z0_cond", 35'(pc_write_cond & (zero ^ bne)), 35'd1);
    tick(); check("bne_z0_cnt", 35'(dp.instr_count), 35'd3);
    zero = 1'b1;
    fetch_decode(OP_BNE);
    check("bne_z1_cond", 35'(pc_write_cond & (zero ^ bne)), 35'd0);
    tick(); check("bne_z1_cnt_wrap", 35'(dp.instr_count), 35'd0);

    // beq, andi, addi.
    fetch_decode(OP_BEQ);
    check("beq_vec", 35'(sv), 35'(V_BEQ));
    check("beq_cond", 35'(pc_write_cond & (zero ^ bne)), 35'd1);
    tick();
    fetch_decode(OP_ANDI);
    check("andi_iexec", 35'(sv), 35'(V_ANDI));
    tick(); check("andi_iwb", 35'(sv), 35'(V_IWB));
    tick();
    fetch_decode(OP_ADDI);
    check("addi_iexec", 35'(sv), 35'(V_MEMADR));
    tick(); tick();
    check("addi_cnt", 35'(dp.instr_count), 35'd3);

    // Four jumps walk the 2-bit counter all the way round.
    fetch_decode(OP_J);
    check("j_vec", 35'(sv), 35'(V_JUMP));
    tick(); check("j1_cnt", 35'(dp.instr_count), 35'd0);
    fetch_decode(OP_J); tick(); check("j2_cnt", 35'(dp.instr_count), 35'd1);
    fetch_decode(OP_J); tick(); check("j3_cnt", 35'(dp.instr_count), 35'd2);
    fetch_decode(OP_J); tick(); check("j4_cnt", 35'(dp.instr_count), 35'd3);

    // sw: ready arrives on the 4th MEMWR cycle, the last one allowed.
    fetch_decode(OP_SW);
    tick();
    tick(); tick(); tick();
    check("sw_limit_wait", 35'(sv), 35'(V_MEMWR));
    set(1'b1, OP_SW);
    tick(); set(1'b0, OP_SW);
    check("sw_limit_ok", 35'(sv), 35'(V_FETCH_W));
    check("sw_limit_nofault", 35'(dp.fault), 35'd0);
    check("sw_cnt", 35'(dp.instr_count), 35'd0);
    fetch_decode(OP_J); tick();

    // sw abandoned by async reset in MEMWR.
    fetch_decode(OP_SW);
    tick();
    check("sw2_memwr", 35'(sv), 35'(V_MEMWR));
    check("sw2_cnt_pre", 35'(dp.instr_count), 35'd1);
    rst_n = 1'b0;
    #1;
    check("arst_strobes", 35'(sv), 35'(V_IDLE));
    check("arst_cnt", 35'(dp.instr_count), 35'd0);
    #2 rst_n = 1'b1;
    tick();

    // Memory timeout in MEMRD.
    fetch_decode(OP_LW);
    tick();
    tick(); tick(); tick();
    check("tmo_memrd", 35'(sv), 35'(V_MEMRD));
    check("tmo_nofault_yet", 35'(dp.fault), 35'd0);
    tick();
    check("tmo_fault", 35'(dp.fault), 35'd1);
    check("tmo_strobes", 35'(sv), 35'(V_IDLE));
    set(1'b1, OP_LW);
    tick(); tick();
    check("tmo_sticky_fault", 35'(dp.fault), 35'd1);
    check("tmo_sticky_strobes", 35'(sv), 35'(V_IDLE));
    rst_n = 1'b0;
    #1 check("tmo_rst_clear", 35'(dp.fault), 35'd0);
    set(1'b0, OP_R);
    #1 rst_n = 1'b1;
    tick();

    // Illegal opcode faults straight out of DECODE.
    fetch_decode(OP_BAD);
    check("bad_fault", 35'(dp.fault), 35'd1);
    check("bad_strobes", 35'(sv), 35'(V_IDLE));
`ifdef MC_SEG_DISPLAY_EN
    check("bad_seg", dp.seg, SEG_ERR);
`else
    check("bad_seg", dp.seg, SEG_OFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
